// File: rtl/fifo_serializer.sv
// fifo_serializer: drains an upstream FIFO one word at a time and sends each
// word on a serial line as start(0), WIDTH data bits LSB first, stop(1).
// Every output is decoded from registered state, so no input reaches an output
// through combinational logic alone.
module fifo_serializer #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_data_i,
  output logic             fifo_read_en_o,
  output logic             tx_o,
  output logic             busy_o,
  output logic             frame_done_o
);

  // A value of 1 would give $clog2 == 0, so both counter widths have a floor of 1.
  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [WIDTH-1:0]   r_shift;
  logic [BAUD_W-1:0]  r_baud;
  logic [IDX_W-1:0]   r_bit_idx;
  logic               w_bit_end;

  // The current bit period ends in this cycle.
  assign w_bit_end = (r_baud == BAUD_LAST);

  // State register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decision. fifo_empty_i is looked at only in IDLE and on the
  // final STOP cycle, so an empty FIFO is never popped.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (!fifo_empty_i) w_next_state = S_READ;
      S_READ:    w_next_state = S_CAPTURE;
      S_CAPTURE: w_next_state = S_START;
      S_START:   if (w_bit_end) w_next_state = S_DATA;
      S_DATA:    if (w_bit_end && (r_bit_idx == IDX_LAST)) w_next_state = S_STOP;
      S_STOP: begin
        if (w_bit_end) begin
          w_next_state = fifo_empty_i ? S_IDLE : S_READ;
        end
      end
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Shift register, baud counter and bit index.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_shift   <= '0;
      r_baud    <= '0;
      r_bit_idx <= '0;
    end else begin
      case (r_state)
        S_CAPTURE: begin
          r_shift   <= fifo_data_i;
          r_baud    <= '0;
          r_bit_idx <= '0;
        end
        S_START, S_STOP: begin
          r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_baud    <= '0;
            r_shift   <= r_shift >> 1;
            r_bit_idx <= r_bit_idx + 1'b1;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_baud <= '0;
        end
      endcase
    end
  end

  // Output decode from the registered state.
  always_comb begin
    fifo_read_en_o = 1'b0;
    tx_o           = 1'b1;
    busy_o         = 1'b1;
    frame_done_o   = 1'b0;
    case (r_state)
      S_IDLE:  busy_o = 1'b0;
      S_READ:  fifo_read_en_o = 1'b1;
      S_START: tx_o = 1'b0;
      S_DATA:  tx_o = r_shift[0];
      S_STOP:  frame_done_o = w_bit_end;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fifo_serializer.sv
// Self-checking bench for fifo_serializer. A behavioural FIFO feeds the DUT; a
// scoreboard records every word written, and a monitor rebuilds each serial
// frame from the tx line and compares it with the ideal frame for that word.
module tb_fifo_serializer;
  localparam int W    = 16;
  localparam int CPB  = 4;
  localparam int FLEN = (W + 2) * CPB;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Main DUT (CLKS_PER_BIT = 4).
  logic [W-1:0] stim_words[$];
  logic [W-1:0] fq[$];
  logic [W-1:0] f_data  = '0;
  logic         f_empty = 1'b1;
  int           taken   = 0;
  logic         rd_en, tx, busy, fdone;

  fifo_serializer #(.WIDTH(W), .CLKS_PER_BIT(CPB)) u_dut (
    .clk_i(clk), .reset_i(rst_n), .fifo_empty_i(f_empty), .fifo_data_i(f_data),
    .fifo_read_en_o(rd_en), .tx_o(tx), .busy_o(busy), .frame_done_o(fdone)
  );

  // Second DUT with 1-cycle bits.
  logic [W-1:0] b_word = '0;
  logic [W-1:0] fb_data = '0;
  int           b_req  = 0;
  int           b_done = 0;
  logic         fb_empty;
  logic         rdb, txb, busyb, fdb;
  assign fb_empty = (b_req == b_done);

  fifo_serializer #(.WIDTH(W), .CLKS_PER_BIT(1)) u_dut_b (
    .clk_i(clk), .reset_i(rst_n), .fifo_empty_i(fb_empty), .fifo_data_i(fb_data),
    .fifo_read_en_o(rdb), .tx_o(txb), .busy_o(busyb), .frame_done_o(fdb)
  );

  // Behavioural FIFOs: a pop at an edge presents the word in the next cycle.
  always @(posedge clk) begin
    if (rd_en && fq.size() != 0) f_data <= fq.pop_front();
    while (taken < stim_words.size()) begin
      fq.push_back(stim_words[taken]);
      taken++;
    end
    f_empty <= (fq.size() == 0);
    if (rdb && (b_done != b_req)) begin
      fb_data <= b_word;
      b_done  <= b_done + 1;
    end
  end

  function automatic logic frame_bit(input logic [W-1:0] w, input int b);
    if (b == 0) return 1'b0;
    else if (b <= W) return w[b-1];
    else return 1'b1;
  endfunction

  // Monitor / scoreboard.
  int   n_chk_m = 0, n_fail_m = 0;
  int   exp_idx = 0, n_pops = 0, cyc = 0, since_pop = 99, gap = 0;
  logic in_frame = 1'b0, prev_rd = 1'b0, b2b_pend = 1'b0;
  logic wave[FLEN];
  logic fdv[FLEN];
  logic bsy[FLEN];

  always @(negedge clk) begin
    if (!rst_n) begin
      n_chk_m++;
      if (tx !== 1'b1 || rd_en !== 1'b0 || busy !== 1'b0 || fdone !== 1'b0) begin
        n_fail_m++;
        $display("FAIL reset_outputs: tx=%b rd_en=%b busy=%b frame_done=%b, required 1 0 0 0",
                 tx, rd_en, busy, fdone);
      end
      if (in_frame) begin
        in_frame = 1'b0;
        exp_idx++;
      end
      b2b_pend = 1'b0;
      since_pop = 99;
      prev_rd = 1'b0;
    end else begin
      if (rd_en) begin
        n_pops++;
        n_chk_m++;
        if (prev_rd || in_frame || f_empty) begin
          n_fail_m++;
          $display("FAIL read_en_pulse: prev_read=%b in_frame=%b fifo_empty=%b, required 0 0 0",
                   prev_rd, in_frame, f_empty);
        end
        since_pop = 0;
      end else if (since_pop < 99) begin
        since_pop++;
      end
      prev_rd = rd_en;

      if (!in_frame && tx === 1'b0) begin
        in_frame = 1'b1;
        cyc = 0;
        n_chk_m++;
        if (since_pop != 2) begin
          n_fail_m++;
          $display("FAIL pop_to_start: %0d cycles, required 2", since_pop);
        end
        if (b2b_pend) begin
          n_chk_m++;
          if (gap != 2) begin
            n_fail_m++;
            $display("FAIL b2b_gap: %0d idle cycles, required 2", gap);
          end
          b2b_pend = 1'b0;
        end
      end

      if (in_frame) begin
        wave[cyc] = tx;
        fdv[cyc]  = fdone;
        bsy[cyc]  = busy;
        cyc++;
        if (cyc == FLEN) begin
          in_frame = 1'b0;
          gap = 0;
          b2b_pend = !f_empty;
          n_chk_m++;
          if (exp_idx >= stim_words.size()) begin
            n_fail_m++;
            $display("FAIL unexpected_frame: frame seen with %0d words expected", exp_idx);
          end else begin
            logic [W-1:0] ew, dec;
            int wbad, dbad, bbad, first;
            ew = stim_words[exp_idx];
            exp_idx++;
            wbad = 0; dbad = 0; bbad = 0; first = -1;
            for (int k = 0; k < FLEN; k++) begin
              if (wave[k] !== frame_bit(ew, k / CPB)) begin
                wbad++;
                if (first < 0) first = k;
              end
              if (fdv[k] !== (k == FLEN - 1)) dbad++;
              if (bsy[k] !== 1'b1) bbad++;
            end
            for (int i = 0; i < W; i++) dec[i] = wave[(i + 1) * CPB + CPB / 2];
            if (wbad != 0) begin
              n_fail_m++;
              $display("FAIL frame_wave: %0d wrong cycles (first at %0d) for word %h", wbad, first, ew);
            end
            n_chk_m++;
            if (dec !== ew) begin
              n_fail_m++;
              $display("FAIL frame_word: decoded %h, required %h", dec, ew);
            end
            n_chk_m++;
            if (dbad != 0) begin
              n_fail_m++;
              $display("FAIL frame_done: %0d wrong cycles, required high only in cycle %0d", dbad, FLEN);
            end
            n_chk_m++;
            if (bbad != 0) begin
              n_fail_m++;
              $display("FAIL frame_busy: busy low in %0d frame cycles, required 0", bbad);
            end
          end
        end
      end else begin
        if (tx === 1'b1) gap++;
        if (fdone !== 1'b0) begin
          n_chk_m++;
          n_fail_m++;
          $display("FAIL frame_done_stray: frame_done=%b outside frame, required 0", fdone);
        end
      end
    end
  end

  // Stimulus.
  int n_chk_s = 0, n_fail_s = 0;

  task automatic push(input logic [W-1:0] w);
    @(posedge clk);
    #1;
    stim_words.push_back(w);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    #1;
    while (!(exp_idx == stim_words.size() && !busy && !in_frame) && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_chk_s++;
    if (n >= limit) begin
      n_fail_s++;
      $display("FAIL drain_timeout: %0d of %0d frames after %0d cycles", exp_idx, stim_words.size(), n);
    end
  endtask

  task automatic wait_cyc(input int c);
    int n = 0;
    while (!(in_frame && cyc >= c) && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_chk_s++;
    if (n >= 500) begin
      n_fail_s++;
      $display("FAIL frame_start_timeout: no frame reached cycle %0d", c);
    end
  endtask

  task automatic run_b(input logic [W-1:0] w);
    int n = 0;
    logic [W+1:0] got, gotd, expw, expd;
    b_word = w;
    @(posedge clk);
    #1;
    b_req++;
    while (txb !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_chk_s++;
    if (n >= 50) begin
      n_fail_s++;
      $display("FAIL cpb1_start_timeout: tx never fell for word %h", w);
    end
    for (int k = 0; k < W + 2; k++) begin
      got[k]  = txb;
      gotd[k] = fdb;
      @(negedge clk);
    end
    expw = {1'b1, w, 1'b0};
    expd = '0;
    expd[W+1] = 1'b1;
    n_chk_s++;
    if (got !== expw) begin
      n_fail_s++;
      $display("FAIL cpb1_wave: got %b, required %b (LSB = first cycle)", got, expw);
    end
    n_chk_s++;
    if (gotd !== expd) begin
      n_fail_s++;
      $display("FAIL cpb1_done: got %b, required %b", gotd, expd);
    end
  endtask

  initial begin
    int n, bad, p0;
    #1 rst_n = 1'b0;

    // Reset held with a non-empty FIFO, then released.
    push(W'($urandom));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    while (rd_en !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    n_chk_s++;
    if (n != 2) begin
      n_fail_s++;
      $display("FAIL first_pop_latency: read_en at sample %0d after release, required 2", n);
    end
    wait_idle(2000);

    // Nothing written for 100 cycles.
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || rd_en !== 1'b0) bad++;
    end
    n_chk_s++;
    if (bad != 0) begin
      n_fail_s++;
      $display("FAIL empty_idle: %0d cycles with tx!=1 or read_en!=0, required 0", bad);
    end

    // Single word.
    p0 = n_pops;
    push(16'hbeef);
    wait_idle(2000);
    n_chk_s++;
    if (n_pops - p0 != 1) begin
      n_fail_s++;
      $display("FAIL single_pop_count: %0d pops, required 1", n_pops - p0);
    end

    // Back-to-back burst.
    p0 = n_pops;
    push(16'hbeef); push(16'hceef); push(16'hdeef); push(16'heeef);
    wait_idle(4000);
    n_chk_s++;
    if (n_pops - p0 != 4 || f_empty !== 1'b1) begin
      n_fail_s++;
      $display("FAIL b2b_pops: %0d pops fifo_empty=%b, required 4 and 1", n_pops - p0, f_empty);
    end

    // Word written while a frame is in flight.
    push(W'($urandom));
    wait_cyc(30);
    push(W'($urandom));
    wait_idle(3000);

    // Reset during data bit 5; the popped word is lost.
    push(16'hdeef);
    wait_cyc(26);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk_s++;
    if (tx !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0) begin
      n_fail_s++;
      $display("FAIL async_reset: tx=%b busy=%b read_en=%b, required 1 0 0", tx, busy, rd_en);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    push(W'($urandom));
    wait_idle(2000);

    // Randomised traffic with random spacing.
    repeat (8) begin
      push(W'($urandom));
      repeat ($urandom_range(0, 2 * FLEN)) @(posedge clk);
    end
    wait_idle(20000);

    n_chk_s++;
    if (n_pops != stim_words.size()) begin
      n_fail_s++;
      $display("FAIL pop_total: %0d pops, required %0d", n_pops, stim_words.size());
    end

    // 1-cycle bits.
    run_b(16'h0001);
    run_b(W'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk_m + n_chk_s, n_fail_m + n_fail_s);
    $finish;
  end

endmodule

// File: doc/fifo_serializer.md
Name: fifo_serializer

Overview:
- Downstream consumer of the `fifo` block.
- Pops one WIDTH-bit word at a time from the FIFO read port and transmits it on a single serial line.
- Frame format: start bit (0), WIDTH data bits LSB first, stop bit (1). Each bit is held for CLKS_PER_BIT clock cycles.
- Sits between the FIFO and the off-block serial link, and drains the FIFO autonomously whenever it is non-empty.

Parameters:
- WIDTH, 16, word width; must match the upstream FIFO WIDTH.
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal values >= 1.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset_i  input  1  asynchronous, active-low reset (0 = in reset).
- fifo_empty_i  input  1  FIFO empty_o.
- fifo_data_i  input  WIDTH  FIFO data_o.
- fifo_read_en_o  output  1  FIFO read_en; pops one word.
- tx_o  output  1  serial line; idles high.
- busy_o  output  1  high from the pop request until the stop bit completes.
- frame_done_o  output  1  one-cycle pulse in the last cycle of each stop bit.

Behaviour:
- Reset (reset_i=0, asynchronous, no clock needed):
  - state=IDLE.
  - tx_o=1, fifo_read_en_o=0, busy_o=0, frame_done_o=0.
  - Shift register, bit counter and baud counter cleared.
- Reset asserted mid-frame: frame aborts immediately and tx_o returns high. The popped word is lost and is not re-read.
- FIFO read timing: read_en is sampled at a rising edge; fifo_data_i is valid during the following cycle.
- All outputs are registered or decoded from the state register. No combinational path from inputs to outputs.
- States:
  - IDLE: tx_o=1, busy_o=0. If fifo_empty_i=0 at the edge, go to READ; otherwise stay.
  - READ: exactly 1 cycle. fifo_read_en_o=1 (only state where it is 1). busy_o=1, tx_o=1. Go to CAPTURE.
  - CAPTURE: exactly 1 cycle. tx_o=1. fifo_data_i is loaded into the shift register at the closing edge. Go to START.
  - START: CLKS_PER_BIT cycles, tx_o=0. Go to DATA with bit index 0.
  - DATA: each bit is held CLKS_PER_BIT cycles. tx_o = shift register bit 0; the register shifts right at the end of each bit period. After WIDTH bits, go to STOP.
  - STOP: CLKS_PER_BIT cycles, tx_o=1. frame_done_o=1 in the final cycle. Exit:
    - fifo_empty_i=0 in that final cycle: go straight to READ (back-to-back).
    - otherwise: go to IDLE.
- Latency:
  - fifo_empty_i falling, sampled at edge E: fifo_read_en_o high in cycle E+1; tx_o falls at edge E+2.
  - Frame length (START through STOP): (WIDTH+2)*CLKS_PER_BIT cycles.
  - Back-to-back gap: 2 idle-high cycles (READ, CAPTURE) between one stop bit and the next start bit.
- Boundary conditions:
  - Never pops an empty FIFO: the READ decision samples fifo_empty_i only in IDLE or the last STOP cycle.
  - fifo_empty_i changing during a frame has no effect.
  - fifo_read_en_o is never high for two consecutive cycles.
  - Exactly one pop per frame.
  - Counter widths use $clog2 of CLKS_PER_BIT and WIDTH, guarded for a value of 1.
  - CLKS_PER_BIT=1 gives 1-cycle bits with no special casing.

Test Plan:
- Reset: hold reset_i=0 with fifo_empty_i=0 for 3 cycles -> tx_o=1, fifo_read_en_o=0, busy_o=0 throughout. Release reset -> fifo_read_en_o pulses 1 cycle, two cycles after release.
- Single word (WIDTH=16, CLKS_PER_BIT=4):
  - Push 16'hbeef into the fifo -> exactly one read_en pulse.
  - tx_o shows 0 for 4 cycles, then bits 1,1,1,1,0,1,1,1,0,1,1,1,1,1,0,1 (4 cycles each), then 1 for 4 cycles.
  - frame_done_o high only in cycle 72 of the frame; returns to IDLE.
- Back-to-back: push 16'hbeef, 16'hceef, 16'hdeef, 16'heeef -> 4 frames, 4 read_en pulses, 2 high cycles between frames, then IDLE with fifo empty_o=1. Bench decodes the same 4 words in order.
- Empty handling: fifo never written for 100 cycles -> fifo_read_en_o never 1, tx_o constantly 1. Write one word mid-frame of a prior word -> it is popped only after that frame's stop bit.
- Mid-frame reset: assert reset_i=0 during DATA bit 5 of 16'hdeef -> tx_o=1 within the same cycle (asynchronous). After release, the next FIFO word transmits correctly and 16'hdeef is not resent.
- CLKS_PER_BIT=1: word 16'h0001 -> tx_o sequence 0,1,0×15,1 over 18 consecutive cycles.
